// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with valid/ready handshake, iterative MUL/MULHU/DIVU/REMU
module alu_seq #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_SLT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] dataInput1,
    input  logic [WIDTH-1:0] dataInput2,
    input  logic [3:0]       sel,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] dataOutput,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [1:0]         op_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               zero_q, ovf_q, err_q;

    logic               accept, is_iter, div_by_zero;
    logic [WIDTH-1:0]   addb, sum, sc_res;
    logic               sc_ovf, sc_err, add_ovf;
    logic [WIDTH:0]     mul_sum, div_sh, div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, acc_step;
    logic [WIDTH-1:0]   iter_res;

    assign accept      = inValid & (state_q == S_IDLE);
    assign div_by_zero = sel[1] & (dataInput2 == '0);
    // 10xx ops iterate, except division by zero which answers immediately
    assign is_iter     = (sel[3:2] == 2'b10) & ~div_by_zero;

    // single-cycle result, flags and add/sub overflow from the live inputs
    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_err  = 1'b0;
        addb    = (sel == 4'b0110) ? (~dataInput2 + WIDTH'(1)) : dataInput2;
        sum     = dataInput1 + addb;
        add_ovf = (dataInput1[WIDTH-1] == addb[WIDTH-1]) & (sum[WIDTH-1] != dataInput1[WIDTH-1]);
        case (sel)
            4'b0000: sc_res = dataInput1 & dataInput2;
            4'b0001: sc_res = dataInput1 | dataInput2;
            4'b0010,
            4'b0110: begin
                sc_res = sum;
                sc_ovf = add_ovf;
            end
            4'b0100: sc_res = ~(dataInput1 | dataInput2);
            4'b0101: sc_res = dataInput1 ^ dataInput2;
            4'b0111: begin
                if (SIGNED_SLT) sc_res = {{(WIDTH-1){1'b0}}, $signed(dataInput1) < $signed(dataInput2)};
                else            sc_res = {{(WIDTH-1){1'b0}}, dataInput1 < dataInput2};
            end
            4'b1010: begin
                sc_res = '1;
                sc_err = 1'b1;
            end
            4'b1011: begin
                sc_res = dataInput1;
                sc_err = 1'b1;
            end
            default: sc_err = (sel[3:2] == 2'b11);
        endcase
    end

    // one shift-add or restoring-divide step on the shared accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? a_q : '0)};
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_sub  = div_sh - {1'b0, b_q};
        div_next = div_ge ? {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                          : {div_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
        acc_step = op_q[1] ? div_next : mul_next;
        iter_res = op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (inValid) state_d = is_iter ? S_BUSY : S_DONE;
            S_BUSY:  if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  if (outReady) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            a_q   <= dataInput1;
            b_q   <= dataInput2;
            op_q  <= sel[1:0];
            cnt_q <= '0;
            // divide shifts the dividend out of the low half; multiply shifts the multiplier
            acc_q <= sel[1] ? {{WIDTH{1'b0}}, dataInput1} : {{WIDTH{1'b0}}, dataInput2};
            if (!is_iter) begin
                res_q  <= sc_res;
                zero_q <= (sc_res == '0);
                ovf_q  <= sc_ovf;
                err_q  <= sc_err;
            end
        end else if (state_q == S_BUSY) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                res_q  <= iter_res;
                zero_q <= (iter_res == '0);
                ovf_q  <= 1'b0;
                err_q  <= 1'b0;
            end
        end
    end

    assign inReady    = (state_q == S_IDLE);
    assign outValid   = (state_q == S_DONE);
    assign dataOutput = res_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=32 and WIDTH=8
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv32 = 1'b0, ir32, ov32, or32 = 1'b0, z32, f32, e32;
    logic [31:0] a32 = '0, b32 = '0, d32;
    logic [3:0]  s32 = '0;

    logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, z8, f8, e8;
    logic [7:0]  a8 = '0, b8 = '0, d8;
    logic [3:0]  s8 = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .SIGNED_SLT(1'b0)) dut32 (
        .clk(clk), .rst_n(rst_n), .inValid(iv32), .inReady(ir32),
        .dataInput1(a32), .dataInput2(b32), .sel(s32),
        .outValid(ov32), .outReady(or32), .dataOutput(d32),
        .zero(z32), .ovf(f32), .err(e32)
    );

    alu_seq #(.WIDTH(8), .SIGNED_SLT(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .inValid(iv8), .inReady(ir8),
        .dataInput1(a8), .dataInput2(b8), .sel(s8),
        .outValid(ov8), .outReady(or8), .dataOutput(d8),
        .zero(z8), .ovf(f8), .err(e8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // issue one op, measure accept-to-outValid latency, check result and flags; result left pending
    task automatic do_op(input string tag, input bit w8, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                         input logic ez, input logic eo, input logic ee, input int elat);
        int guard;
        int lat;
        guard = 0;
        while (!(w8 ? ir8 : ir32) && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, ".ready"}, {63'b0, (w8 ? ir8 : ir32)}, 64'd1);
        if (w8) begin
            iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
        end else begin
            iv32 = 1'b1; a32 = a; b32 = b; s32 = s;
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        iv32 = 1'b0;
        lat = 1;
        while (!(w8 ? ov8 : ov32) && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".lat"},  64'(lat), 64'(elat));
        chk({tag, ".data"}, w8 ? {56'b0, d8} : {32'b0, d32}, {32'b0, er});
        chk({tag, ".zero"}, {63'b0, (w8 ? z8 : z32)}, {63'b0, ez});
        chk({tag, ".ovf"},  {63'b0, (w8 ? f8 : f32)}, {63'b0, eo});
        chk({tag, ".err"},  {63'b0, (w8 ? e8 : e32)}, {63'b0, ee});
    endtask

    // consume the pending result; inValid is left as the caller set it across the handshake edge
    task automatic consume(input string tag, input bit w8);
        if (w8) or8 = 1'b1; else or32 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        or32 = 1'b0;
        chk({tag, ".drained"}, {63'b0, (w8 ? ov8 : ov32)}, 64'd0);
        chk({tag, ".idle"},    {63'b0, (w8 ? ir8 : ir32)}, 64'd1);
        iv8 = 1'b0;
        iv32 = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.outValid", {63'b0, ov32}, 64'd0);
        chk("rst.data",     {32'b0, d32},  64'd0);
        chk("rst.flags",    {61'b0, z32, f32, e32}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst.inReady32", {63'b0, ir32}, 64'd1);
        chk("rst.inReady8",  {63'b0, ir8},  64'd1);

        // WIDTH=32 single-cycle ops
        do_op("add_ovf", 1'b0, 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0, 1); consume("add_ovf", 1'b0);
        do_op("sub_eq",  1'b0, 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1);              consume("sub_eq", 1'b0);
        do_op("and_z",   1'b0, 4'b0000, 32'hF0, 32'h0F, 32'd0, 1'b1, 1'b0, 1'b0, 1);            consume("and_z", 1'b0);
        do_op("sub_ovf", 1'b0, 4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1); consume("sub_ovf", 1'b0);
        do_op("or",      1'b0, 4'b0001, 32'hA0A0_0000, 32'h0000_0505, 32'hA0A0_0505, 1'b0, 1'b0, 1'b0, 1); consume("or", 1'b0);
        do_op("nor",     1'b0, 4'b0100, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1);        consume("nor", 1'b0);
        do_op("xor",     1'b0, 4'b0101, 32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0, 1); consume("xor", 1'b0);
        do_op("nop",     1'b0, 4'b0011, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1'b0, 1);         consume("nop", 1'b0);
        do_op("slt_lt",  1'b0, 4'b0111, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0, 1'b0, 1);               consume("slt_lt", 1'b0);
        do_op("slt_uns", 1'b0, 4'b0111, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1);        consume("slt_uns", 1'b0);
        do_op("rsvd",    1'b0, 4'b1101, 32'd7, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1, 1);               consume("rsvd", 1'b0);

        // WIDTH=32 iterative ops and divide-by-zero
        do_op("mul",     1'b0, 4'b1000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33); consume("mul", 1'b0);
        do_op("mulhu",   1'b0, 4'b1001, 32'hFFFFFFFF, 32'd2, 32'h00000001, 1'b0, 1'b0, 1'b0, 33); consume("mulhu", 1'b0);
        do_op("divu",    1'b0, 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33);            consume("divu", 1'b0);
        do_op("remu",    1'b0, 4'b1011, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 33);             consume("remu", 1'b0);
        do_op("divu0",   1'b0, 4'b1010, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1);         consume("divu0", 1'b0);
        do_op("remu0",   1'b0, 4'b1011, 32'd9, 32'd0, 32'd9, 1'b0, 1'b0, 1'b1, 1);                consume("remu0", 1'b0);

        // DONE held for 10 cycles with inValid pulses and changing operands
        do_op("hold", 1'b0, 4'b0010, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 1'b0, 1);
        for (int i = 0; i < 10; i++) begin
            iv32 = i[0];
            a32  = 32'(i * 3 + 1);
            s32  = 4'(i);
            @(posedge clk); #1;
            chk("hold.data",    {32'b0, d32}, 64'd42);
            chk("hold.valid",   {63'b0, ov32}, 64'd1);
            chk("hold.inReady", {63'b0, ir32}, 64'd0);
        end
        iv32 = 1'b1;
        consume("hold", 1'b0);
        do_op("after_hold", 1'b0, 4'b0110, 32'd10, 32'd3, 32'd7, 1'b0, 1'b0, 1'b0, 1); consume("after_hold", 1'b0);

        // reset asserted mid-division
        do_op("pre_rst", 1'b0, 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 33); consume("pre_rst", 1'b0);
        iv32 = 1'b1; a32 = 32'd1000; b32 = 32'd3; s32 = 4'b1010;
        @(posedge clk); #1;
        iv32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst.busy", {63'b0, ir32}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst.data",  {32'b0, d32}, 64'd0);
        chk("midrst.valid", {63'b0, ov32}, 64'd0);
        chk("midrst.flags", {61'b0, z32, f32, e32}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst.inReady", {63'b0, ir32}, 64'd1);
        do_op("post_rst_add", 1'b0, 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1); consume("post_rst_add", 1'b0);

        // WIDTH=8 reruns
        do_op("w8_add_ovf", 1'b1, 4'b0010, 32'h7F, 32'h1, 32'h80, 1'b0, 1'b1, 1'b0, 1); consume("w8_add_ovf", 1'b1);
        do_op("w8_divu",    1'b1, 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 1'b0, 9); consume("w8_divu", 1'b1);
        do_op("w8_remu",    1'b1, 4'b1011, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 1'b0, 9);  consume("w8_remu", 1'b1);
        do_op("w8_divu0",   1'b1, 4'b1010, 32'd9, 32'd0, 32'hFF, 1'b0, 1'b0, 1'b1, 1);   consume("w8_divu0", 1'b1);
        do_op("w8_mul",     1'b1, 4'b1000, 32'hFF, 32'd2, 32'hFE, 1'b0, 1'b0, 1'b0, 9);  consume("w8_mul", 1'b1);
        do_op("w8_mulhu",   1'b1, 4'b1001, 32'hFF, 32'hFF, 32'hFE, 1'b0, 1'b0, 1'b0, 9); consume("w8_mulhu", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
